// File: rtl/seven_segment_reader.sv
// Debounced reader for a two-digit seven-segment display: samples both digits,
// commits a value once the pattern is stable, and tracks counting-sequence errors.
module seven_segment_reader #(
  parameter int unsigned STABLE_CYCLES = 600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg1,
  input  logic [6:0] seg10,
  output logic [3:0] digit1,
  output logic [3:0] digit10,
  output logic [6:0] value,
  output logic       valid,
  output logic       error,
  output logic       change,
  output logic       seq_error
);

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned SAMPLE_W = 2 * SEG_W;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DIG_W    = 4;
  localparam int unsigned VAL_W    = 7;

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [VAL_W-1:0] VAL_LAST   = VAL_W'(99);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Returns {legal, digit}; blank_ok lets an unlit tens digit read as zero.
  function automatic logic [DIG_W:0] decode_seg(input logic [SEG_W-1:0] pat,
                                                input logic             blank_ok);
    logic [DIG_W:0] res;
    res = '0;
    case (pat)
      7'h3F: res = {1'b1, 4'd0};
      7'h06: res = {1'b1, 4'd1};
      7'h5B: res = {1'b1, 4'd2};
      7'h4F: res = {1'b1, 4'd3};
      7'h66: res = {1'b1, 4'd4};
      7'h6D: res = {1'b1, 4'd5};
      7'h7D: res = {1'b1, 4'd6};
      7'h07: res = {1'b1, 4'd7};
      7'h7F: res = {1'b1, 4'd8};
      7'h6F: res = {1'b1, 4'd9};
      7'h00: res = {blank_ok, 4'd0};
      default: res = '0;
    endcase
    return res;
  endfunction

  state_e               state_q, state_d;
  logic [SAMPLE_W-1:0]  sample_q, sample_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIG_W-1:0]     digit1_q, digit1_d;
  logic [DIG_W-1:0]     digit10_q, digit10_d;
  logic [VAL_W-1:0]     value_q, value_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 change_q, change_d;
  logic                 seq_error_q, seq_error_d;
  logic [VAL_W-1:0]     last_q, last_d;
  logic                 have_last_q, have_last_d;

  logic [SAMPLE_W-1:0]  seg_new;
  logic                 same;
  logic                 commit;
  logic [DIG_W:0]       dec1;
  logic [DIG_W:0]       dec10;
  logic                 legal;
  logic [VAL_W-1:0]     new_value;
  logic [VAL_W-1:0]     next_expected;

  // State register and all output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= SETTLE;
      sample_q    <= '0;
      cnt_q       <= '0;
      digit1_q    <= '0;
      digit10_q   <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      change_q    <= 1'b0;
      seq_error_q <= 1'b0;
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      cnt_q       <= cnt_d;
      digit1_q    <= digit1_d;
      digit10_q   <= digit10_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      change_q    <= change_d;
      seq_error_q <= seq_error_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
    end
  end

  // Next-state: stability tracking, commit decision and committed-value update
  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    cnt_d         = cnt_q;
    digit1_d      = digit1_q;
    digit10_d     = digit10_q;
    value_d       = value_q;
    valid_d       = valid_q;
    error_d       = error_q;
    change_d      = 1'b0;
    seq_error_d   = seq_error_q;
    last_d        = last_q;
    have_last_d   = have_last_q;
    seg_new       = {seg10, seg1};
    same          = 1'b0;
    commit        = 1'b0;
    dec1          = '0;
    dec10         = '0;
    legal         = 1'b0;
    new_value     = '0;
    next_expected = '0;

    sample_d = seg_new;
    same     = (seg_new == sample_q);

    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    commit = (state_q == SETTLE) && same && (cnt_q == CNT_COMMIT);

    case (state_q)
      SETTLE:  if (commit) state_d = LOCKED;
      LOCKED:  if (!same)  state_d = SETTLE;
      default: state_d = SETTLE;
    endcase

    // The held sample equals the incoming one on a commit edge, so decode the register
    dec1      = decode_seg(sample_q[SEG_W-1:0], 1'b0);
    dec10     = decode_seg(sample_q[SAMPLE_W-1:SEG_W], 1'b1);
    legal     = dec1[DIG_W] && dec10[DIG_W];
    new_value = ({3'b000, dec10[DIG_W-1:0]} * VAL_W'(10)) + {3'b000, dec1[DIG_W-1:0]};
    next_expected = (last_q == VAL_LAST) ? '0 : last_q + VAL_W'(1);

    if (commit) begin
      if (legal) begin
        digit1_d    = dec1[DIG_W-1:0];
        digit10_d   = dec10[DIG_W-1:0];
        value_d     = new_value;
        valid_d     = 1'b1;
        error_d     = 1'b0;
        change_d    = !have_last_q || (new_value != last_q);
        if (have_last_q && (new_value != last_q) && (new_value != next_expected)
            && (new_value != '0)) begin
          seq_error_d = 1'b1;
        end
        last_d      = new_value;
        have_last_d = 1'b1;
      end else begin
        valid_d = 1'b0;
        error_d = 1'b1;
      end
    end
  end

  assign digit1    = digit1_q;
  assign digit10   = digit10_q;
  assign value     = value_q;
  assign valid     = valid_q;
  assign error     = error_q;
  assign change    = change_q;
  assign seq_error = seq_error_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader: STABLE_CYCLES=4 instance for function
// and a STABLE_CYCLES=600 instance for the long debounce window.
module tb_seven_segment_reader;

  logic       clk;
  logic       rst_n;
  logic [6:0] s1, s10;
  logic [3:0] d1, d10;
  logic [6:0] val;
  logic       vld, err, chg, seq;

  logic       rst600;
  logic [6:0] a1, a10;
  logic [3:0] b_d1, b_d10;
  logic [6:0] b_val;
  logic       b_vld, b_err, b_chg, b_seq;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;
  int d;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seven_segment_reader #(.STABLE_CYCLES(4)) u_dut (
    .clock(clk), .reset(rst_n), .seg1(s1), .seg10(s10),
    .digit1(d1), .digit10(d10), .value(val), .valid(vld), .error(err),
    .change(chg), .seq_error(seq)
  );

  seven_segment_reader #(.STABLE_CYCLES(600)) u_dut600 (
    .clock(clk), .reset(rst600), .seg1(a1), .seg10(a10),
    .digit1(b_d1), .digit10(b_d10), .value(b_val), .valid(b_vld), .error(b_err),
    .change(b_chg), .seq_error(b_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input int e_d10, input int e_d1, input int e_val,
                         input int e_vld, input int e_err, input int e_chg, input int e_seq);
    chk({tag, ".digit10"},   32'(d10), e_d10);
    chk({tag, ".digit1"},    32'(d1),  e_d1);
    chk({tag, ".value"},     32'(val), e_val);
    chk({tag, ".valid"},     32'(vld), e_vld);
    chk({tag, ".error"},     32'(err), e_err);
    chk({tag, ".change"},    32'(chg), e_chg);
    chk({tag, ".seq_error"}, 32'(seq), e_seq);
  endtask

  task automatic drive(input logic [6:0] p10, input logic [6:0] p1);
    s10 = p10;
    s1  = p1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst600 = 1'b0;
    s1 = '0; s10 = '0; a1 = '0; a10 = '0;
    tick(2);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);

    // First legal commit: blank tens, units 0, exact latency of 4 edges after the change edge
    drive(7'h00, 7'h3F);
    rst_n = 1'b1;
    tick(4);
    chk("first.pre_commit_valid", 32'(vld), 0);
    tick(1);
    chk_all("first.commit", 0, 0, 0, 1, 0, 1, 0);
    tick(1);
    chk("first.pulse_end", 32'(chg), 0);

    // Count 1..99 then wrap to 0
    pulses = 0;
    for (int v = 1; v <= 100; v++) begin
      d = v % 100;
      drive(seg_tab[d / 10], seg_tab[d % 10]);
      tick(5);
      chk("count.value", 32'(val), 32'(d));
      if (chg) pulses++;
      tick(1);
      if (chg) pulses++;
    end
    chk("count.pulses", 32'(pulses), 100);
    chk_all("count.wrap", 0, 0, 0, 1, 0, 0, 0);

    // Illegal pattern holds value, then recovers to the next count
    pulse_reset();
    drive(7'h3F, 7'h6D);
    tick(5);
    chk_all("d05", 0, 5, 5, 1, 0, 1, 0);
    tick(1);
    drive(7'h3F, 7'h7E);
    tick(5);
    chk_all("illegal", 0, 5, 5, 0, 1, 0, 0);
    drive(7'h3F, 7'h7D);
    tick(5);
    chk_all("d06", 0, 6, 6, 1, 0, 1, 0);
    tick(1);
    drive(7'h3F, 7'h7E);
    tick(5);
    chk_all("illegal2", 0, 6, 6, 0, 1, 0, 0);
    drive(7'h3F, 7'h7D);
    tick(5);
    chk_all("repeat06", 0, 6, 6, 1, 0, 0, 0);

    // Short glitch on the units digit is ignored
    pulse_reset();
    drive(7'h06, 7'h5B);
    tick(5);
    chk_all("d12", 1, 2, 12, 1, 0, 1, 0);
    tick(1);
    drive(7'h06, 7'h4F);
    tick(3);
    drive(7'h06, 7'h5B);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (chg) pulses++;
      chk("glitch.value", 32'(val), 12);
    end
    chk("glitch.pulses", 32'(pulses), 0);
    chk_all("glitch.end", 1, 2, 12, 1, 0, 0, 0);

    // Out-of-sequence jump sets a sticky flag cleared only by reset
    pulse_reset();
    drive(7'h5B, 7'h3F);
    tick(5);
    chk_all("d20", 2, 0, 20, 1, 0, 1, 0);
    tick(1);
    drive(7'h5B, 7'h6D);
    tick(5);
    chk_all("d25", 2, 5, 25, 1, 0, 1, 1);
    tick(1);
    drive(7'h5B, 7'h7D);
    tick(5);
    chk_all("d26", 2, 6, 26, 1, 0, 1, 1);
    rst_n = 1'b0;
    tick(1);
    chk_all("reset2", 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of settling aborts, then a full stable period is needed
    rst_n = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk_all("midsettle.reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(4);
    chk("midsettle.no_early", 32'(vld), 0);
    tick(1);
    chk_all("midsettle.commit", 2, 6, 26, 1, 0, 1, 0);

    // Long window: 300 cycles is too short, 600 commits exactly
    a10 = 7'h00;
    a1  = 7'h06;
    rst600 = 1'b1;
    tick(300);
    chk("w600.half_valid", 32'(b_vld), 0);
    a1 = 7'h5B;
    tick(600);
    chk("w600.pre_valid", 32'(b_vld), 0);
    chk("w600.pre_value", 32'(b_val), 0);
    tick(1);
    chk("w600.valid", 32'(b_vld), 1);
    chk("w600.value", 32'(b_val), 2);
    chk("w600.change", 32'(b_chg), 1);
    chk("w600.error", 32'(b_err), 0);
    tick(1);
    chk("w600.pulse_end", 32'(b_chg), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
